dram_ctrl: RTL and testbench
============================

# dram_ctrl

Multi-cycle data-RAM controller between the `mem` stage and the external synchronous data SRAM. It consumes the `mem` stage's RAM request (address, write request, write data, memory op) and returns the word read back, stalling the pipeline until the access completes. Sub-word stores (SB/SH) are done as read-merge-write: the controller reads the word, `mem` merges the byte or half combinationally, and the controller writes the merged word back. Full-word SW writes directly.

## Interface
Parameters:
- `SRAM_AW`, default 16: SRAM word-address width.
- `TIMEOUT`, default 15: maximum cycles to wait for `sram_ready_i` per phase.

Ports:
- `clk_i`  in  1: clock. One clock domain.
- `rst_i`  in  1: reset, synchronous, active-high.
- `mem_op_i`  in  4: op from `mem` (the LB/LH/LW/LBU/LHU/SB/SH/SW/NONE codes from `defines.v`).
- `ram_addr_i`  in  `ADDR_WIDTH`: byte address from `mem`.
- `ram_w_request_i`  in  1: write request from `mem`.
- `ram_data_i`  in  `DATA_WIDTH`: write or merged data from `mem`.
- `hold_i`  in  1: pipeline held by another source; keeps the controller in DONE.
- `rdata_o`  out  `DATA_WIDTH`: word returned to `mem` (registered).
- `stall_o`  out  1: stall request to pipeline control (combinational).
- `misalign_o`  out  1: misaligned access flag, valid in DONE.
- `err_o`  out  1: SRAM timeout flag, valid in DONE.
- `sram_ce_o`  out  1: SRAM chip enable.
- `sram_we_o`  out  1: SRAM write enable.
- `sram_addr_o`  out  `SRAM_AW`: SRAM word address, equal to `addr_q[SRAM_AW+1:2]`.
- `sram_wdata_o`  out  `DATA_WIDTH`: SRAM write data.
- `sram_rdata_i`  in  `DATA_WIDTH`: SRAM read data, valid when `sram_ready_i` is high.
- `sram_ready_i`  in  1: SRAM completion, may be high in the same cycle as `sram_ce_o`.

## Operation
- `req` is high when `mem_op_i` is any of the eight load/store codes. NONE is idle.
- Misaligned means:
  - LW/SW with `addr[1:0]` != 0, or
  - LH/LHU/SH with `addr[0]` = 1.
- States: IDLE, RD, MERGE, WR, DONE.
- IDLE:
  - On `req`, latch `addr_q` and `op_q`.
  - Misaligned access: go to DONE with `misalign` set and `rdata_o` = 0. No SRAM access is made.
  - SW: go to WR with `wdata_q` = `ram_data_i`.
  - Any load, SB or SH: go to RD.
- RD:
  - `sram_ce_o`=1, `sram_we_o`=0.
  - On `sram_ready_i`, capture `rdata_o` = `sram_rdata_i`. Loads go to DONE; SB/SH go to MERGE.
- MERGE: one cycle. `mem` sees the new `rdata_o` and drives the merged word. Capture `wdata_q` = `ram_data_i`, then go to WR.
- WR:
  - `sram_ce_o`=1, `sram_we_o`=1, `sram_wdata_o` = `wdata_q`.
  - On `sram_ready_i`, go to DONE.
- DONE:
  - `stall_o`=0, so the pipeline advances at this edge.
  - Stay in DONE while `hold_i` is high; otherwise go to IDLE.
- `stall_o` = (IDLE & `req`) | RD | MERGE | WR.
- Timeout:
  - The wait counter clears on entering RD or WR and increments each cycle without ready.
  - When the count reaches `TIMEOUT`, set `err` and go to DONE. `rdata_o` is 0 for a read timeout; `ram_data_i` is ignored.
- `err` and `misalign` clear on leaving DONE.
- Address, op and write data are registered and held stable until ready. Changes on the `mem` inputs outside IDLE/MERGE are ignored.

## Timing
- Reset values: state IDLE; `rdata_o`, `wdata_q`, `addr_q`, counter, `misalign_o`, `err_o`, `sram_ce_o`, `sram_we_o`, `sram_addr_o`, `sram_wdata_o` all 0. `stall_o` = 0 because `req` is ignored during reset.
- Zero-wait SRAM, cycles spent in `mem` (`stall_o` high in all but the last):
  - load: 3 (IDLE, RD, DONE)
  - SW: 3 (IDLE, WR, DONE)
  - SB/SH: 5 (IDLE, RD, MERGE, WR, DONE)
  - misaligned: 2 (IDLE, DONE)
- Each SRAM wait cycle adds one cycle to RD or WR.
- Back-to-back accesses: the next instruction arrives at the DONE→IDLE edge and is accepted in the following IDLE cycle. There are no idle bubbles beyond IDLE itself.
- `sram_ready_i` arriving in the same cycle the counter hits `TIMEOUT`: ready wins and `err` is not set.
- Reset mid-access: at the reset edge, state goes to IDLE and `sram_ce_o` drops. The SRAM transaction is abandoned with no retry.

## Structure
- Add the state encodings `DRAM_IDLE`..`DRAM_DONE` to `defines.v`, next to the existing op codes. `ADDR_WIDTH` and `DATA_WIDTH` are reused from there.
- One sub-module, `dram_wait_timer`:
  - inputs: clear and count enable
  - output: expired
  - parameter: `TIMEOUT`
- Top-level integration ORs `stall_o` into the pipeline-control stall vector.

## Test plan
- LW at 0x0000_0010, SRAM returns 0xDEADBEEF with zero wait → `sram_addr_o`=4, `stall_o` high for 2 cycles, `rdata_o`=0xDEADBEEF in DONE.
- SB of 0xAB at 0x0000_0011; word holds 0x11223344 and `mem` merges to 0x1122AB44 → sequence RD, MERGE, WR; write data = 0x1122AB44; 4 stall cycles.
- SW of 0xCAFEF00D with `sram_ready_i` delayed 3 cycles → no read issued, WR lasts 4 cycles, `sram_wdata_o` stable throughout.
- LW at 0x0000_0012 → `misalign_o`=1 in DONE, `sram_ce_o` never asserted, `rdata_o`=0.
- `sram_ready_i` held low, `TIMEOUT`=15 → `err_o`=1 after 15 wait cycles, `stall_o` released; `rst_i` asserted mid-RD → next cycle in IDLE with `sram_ce_o`=0.

Source files
------------

// File: rtl/dram_ctrl_pkg.sv
// dram_ctrl_pkg: shared widths, mem op codes, controller state encodings and access classifiers
package dram_ctrl_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_LB   = 4'd1;
  localparam logic [3:0] OP_LH   = 4'd2;
  localparam logic [3:0] OP_LW   = 4'd3;
  localparam logic [3:0] OP_LBU  = 4'd4;
  localparam logic [3:0] OP_LHU  = 4'd5;
  localparam logic [3:0] OP_SB   = 4'd6;
  localparam logic [3:0] OP_SH   = 4'd7;
  localparam logic [3:0] OP_SW   = 4'd8;
  typedef enum logic [2:0] {
    DRAM_IDLE,
    DRAM_RD,
    DRAM_MERGE,
    DRAM_WR,
    DRAM_DONE
  } dram_state_t;
  function automatic logic is_req(input logic [3:0] op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
  endfunction
  function automatic logic is_sub_store(input logic [3:0] op);
    return op inside {OP_SB, OP_SH};
  endfunction
  function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] a);
    return ((op == OP_LW || op == OP_SW) && a != 2'b00) ||
           ((op == OP_LH || op == OP_LHU || op == OP_SH) && a[0]);
  endfunction
endpackage

// File: rtl/dram_ctrl_wait_timer.sv
// dram_wait_timer: per-phase SRAM wait counter; expired once TIMEOUT cycles without ready have elapsed
//   clk, rst : clock, synchronous active-high reset
//   clr      : hold the count at zero (outside the RD/WR phases)
//   en       : count this cycle (no ready seen)
//   expired  : count has reached TIMEOUT
module dram_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT + 2);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    cnt <= (rst || clr) ? '0 : (en && !expired) ? cnt + 1'b1 : cnt;
  assign expired = cnt == W'(TIMEOUT);
endmodule

// File: rtl/dram_ctrl.sv
// dram_ctrl: multi-cycle data-RAM controller between the mem stage and a synchronous data SRAM
//   clk_i, rst_i      : clock, synchronous active-high reset
//   mem_op_i, ram_*_i : request from mem (op, byte address, write request, write/merged data)
//   hold_i            : pipeline held elsewhere; keeps the controller in DONE
//   rdata_o           : registered word read back to mem
//   stall_o           : combinational stall request to pipeline control
//   misalign_o, err_o : misaligned-access and SRAM-timeout flags, valid in DONE
//   sram_*            : SRAM chip enable, write enable, word address, write/read data, ready
module dram_ctrl
  import dram_ctrl_pkg::*;
#(
  parameter int SRAM_AW = 16,
  parameter int TIMEOUT = 15
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [3:0]            mem_op_i,
  input  logic [ADDR_WIDTH-1:0] ram_addr_i,
  input  logic                  ram_w_request_i,
  input  logic [DATA_WIDTH-1:0] ram_data_i,
  input  logic                  hold_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  stall_o,
  output logic                  misalign_o,
  output logic                  err_o,
  output logic                  sram_ce_o,
  output logic                  sram_we_o,
  output logic [SRAM_AW-1:0]    sram_addr_o,
  output logic [DATA_WIDTH-1:0] sram_wdata_o,
  input  logic [DATA_WIDTH-1:0] sram_rdata_i,
  input  logic                  sram_ready_i
);
  dram_state_t           state;
  logic [3:0]            op_q;
  logic [SRAM_AW-1:0]    addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  req;
  logic                  expired;
  logic                  busy;
  logic                  unused_addr_bits;
  assign req              = is_req(mem_op_i);
  assign busy             = state inside {DRAM_RD, DRAM_MERGE, DRAM_WR};
  assign stall_o          = (state == DRAM_IDLE && req && !rst_i) || busy;
  assign sram_addr_o      = addr_q;
  assign sram_wdata_o     = wdata_q;
  assign unused_addr_bits = ^ram_addr_i[ADDR_WIDTH-1:SRAM_AW+2];
  // Counter is held clear in every state that precedes RD or WR, so each phase starts from zero.
  dram_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk_i),
    .rst     (rst_i),
    .clr     (!(state == DRAM_RD || state == DRAM_WR)),
    .en      (!sram_ready_i),
    .expired (expired)
  );
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= DRAM_IDLE;
      op_q       <= OP_NONE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_o    <= '0;
      misalign_o <= 1'b0;
      err_o      <= 1'b0;
      sram_ce_o  <= 1'b0;
      sram_we_o  <= 1'b0;
    end else begin
      case (state)
        DRAM_IDLE: if (req) begin
          op_q    <= mem_op_i;
          addr_q  <= ram_addr_i[SRAM_AW+1:2];
          rdata_o <= '0;
          if (is_misaligned(mem_op_i, ram_addr_i[1:0])) begin
            misalign_o <= 1'b1;
            state      <= DRAM_DONE;
          end else if (mem_op_i == OP_SW && ram_w_request_i) begin
            wdata_q   <= ram_data_i;
            sram_ce_o <= 1'b1;
            sram_we_o <= 1'b1;
            state     <= DRAM_WR;
          end else begin
            sram_ce_o <= 1'b1;
            state     <= DRAM_RD;
          end
        end
        // Ready is checked before expiry so a late ready on the last allowed cycle still completes.
        DRAM_RD: if (sram_ready_i || expired) begin
          rdata_o   <= sram_ready_i ? sram_rdata_i : '0;
          err_o     <= !sram_ready_i;
          sram_ce_o <= 1'b0;
          state     <= (sram_ready_i && is_sub_store(op_q)) ? DRAM_MERGE : DRAM_DONE;
        end
        DRAM_MERGE: begin
          wdata_q   <= ram_data_i;
          sram_ce_o <= 1'b1;
          sram_we_o <= 1'b1;
          state     <= DRAM_WR;
        end
        DRAM_WR: if (sram_ready_i || expired) begin
          err_o     <= !sram_ready_i;
          sram_ce_o <= 1'b0;
          sram_we_o <= 1'b0;
          state     <= DRAM_DONE;
        end
        DRAM_DONE: if (!hold_i) begin
          misalign_o <= 1'b0;
          err_o      <= 1'b0;
          state      <= DRAM_IDLE;
        end
        default: state <= DRAM_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dram_ctrl.sv
// tb_dram_ctrl: randomized self-checking bench for dram_ctrl against a transaction-level model
module tb_dram_ctrl;
  import dram_ctrl_pkg::*;
  localparam int TO = 15;
  logic                  clk_i = 1'b0;
  logic                  rst_i;
  logic [3:0]            mem_op_i;
  logic [ADDR_WIDTH-1:0] ram_addr_i;
  logic                  ram_w_request_i;
  logic [DATA_WIDTH-1:0] ram_data_i;
  logic                  hold_i;
  logic [DATA_WIDTH-1:0] rdata_o;
  logic                  stall_o;
  logic                  misalign_o;
  logic                  err_o;
  logic                  sram_ce_o;
  logic                  sram_we_o;
  logic [15:0]           sram_addr_o;
  logic [DATA_WIDTH-1:0] sram_wdata_o;
  logic [DATA_WIDTH-1:0] sram_rdata_i;
  logic                  sram_ready_i;
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] sram [64];
  logic [31:0] ref_mem [64];
  int rd_lat, wr_lat, ph, rd_cyc, wr_cyc;
  logic [31:0] last_wdata;
  logic wstable;
  logic [15:0] seen_addr;
  always #5 clk_i = ~clk_i;
  dram_ctrl #(.SRAM_AW(16), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .mem_op_i(mem_op_i), .ram_addr_i(ram_addr_i),
    .ram_w_request_i(ram_w_request_i), .ram_data_i(ram_data_i), .hold_i(hold_i),
    .rdata_o(rdata_o), .stall_o(stall_o), .misalign_o(misalign_o), .err_o(err_o),
    .sram_ce_o(sram_ce_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
    .sram_wdata_o(sram_wdata_o), .sram_rdata_i(sram_rdata_i), .sram_ready_i(sram_ready_i)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] v,
                                        input logic [1:0] a, input logic [3:0] op);
    logic [31:0] r;
    r = w;
    if (op == OP_SB) r[8*a +: 8] = v[7:0];
    else if (op == OP_SH) r[16*a[1] +: 16] = v[15:0];
    else r = v;
    return r;
  endfunction
  function automatic int pick_lat();
    int r;
    r = $urandom_range(0, 9);
    return r < 7 ? r % 4 : r == 7 ? TO : r == 8 ? TO + 1 : 0;
  endfunction
  // SRAM device model: ready after rd_lat/wr_lat cycles of chip enable in a phase
  initial forever begin
    @(negedge clk_i);
    sram_ready_i = 1'b0;
    sram_rdata_i = $urandom;
    if (sram_ce_o) begin
      seen_addr = sram_addr_o;
      if (sram_we_o) begin
        wr_cyc++;
        if (ph > 0 && sram_wdata_o !== last_wdata) wstable = 1'b0;
        last_wdata = sram_wdata_o;
        if (ph >= wr_lat) begin
          sram_ready_i = 1'b1;
          sram[sram_addr_o[5:0]] = sram_wdata_o;
        end
      end else begin
        rd_cyc++;
        if (ph >= rd_lat) begin
          sram_ready_i = 1'b1;
          sram_rdata_i = sram[sram_addr_o[5:0]];
        end
      end
      ph++;
    end else ph = 0;
  end
  task automatic access(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] val,
                        input int rl, input int wl, input int hold);
    int idx = int'(addr[7:2]);
    bit st = op inside {OP_SB, OP_SH, OP_SW};
    bit sub = op inside {OP_SB, OP_SH};
    bit mis = (op inside {OP_LW, OP_SW}) ? addr[1:0] != 2'b00 :
              (op inside {OP_LH, OP_LHU, OP_SH}) ? addr[0] : 1'b0;
    bit rto = rl > TO;
    bit wto = wl > TO;
    bit do_rd = !mis && op != OP_SW;
    bit do_wr = !mis && (op == OP_SW || (sub && !rto));
    int exp_rc = do_rd ? (rto ? TO + 1 : rl + 1) : 0;
    int exp_wc = do_wr ? (wto ? TO + 1 : wl + 1) : 0;
    int exp_stall = 1 + exp_rc + ((sub && do_rd && !rto) ? 1 : 0) + exp_wc;
    bit exp_err = (do_rd && rto) || (do_wr && wto);
    logic [31:0] exp_rdata = (do_rd && !rto) ? ref_mem[idx] : 32'h0;
    int cycles = 0;
    check("clr_err", err_o, 0);
    check("clr_mis", misalign_o, 0);
    rd_lat = rl; wr_lat = wl; rd_cyc = 0; wr_cyc = 0; wstable = 1'b1; seen_addr = 16'hFFFF;
    mem_op_i = op; ram_addr_i = addr; ram_w_request_i = st; ram_data_i = val;
    #1;
    while (stall_o === 1'b1 && cycles < 300) begin
      cycles++;
      @(negedge clk_i);
      ram_addr_i = $urandom;
      ram_w_request_i = $urandom;
      ram_data_i = sub ? merge(rdata_o, val, addr[1:0], op) : $urandom;
      #1;
    end
    check("stall_cycles", cycles, exp_stall);
    check("misalign", misalign_o, mis);
    check("err", err_o, exp_err);
    check("rd_cycles", rd_cyc, exp_rc);
    check("wr_cycles", wr_cyc, exp_wc);
    check("wdata_stable", wstable, 1);
    if (op != OP_SW) check("rdata", rdata_o, exp_rdata);
    if (do_rd || do_wr) check("sram_addr", seen_addr, addr[17:2]);
    if (do_wr && !wto) ref_mem[idx] = merge(ref_mem[idx], val, addr[1:0], op);
    if (st) check("mem_word", sram[idx], ref_mem[idx]);
    hold_i = hold > 0;
    mem_op_i = 4'($urandom_range(1, 8));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk_i);
      #1;
      check("hold_stall", stall_o, 0);
      check("hold_mis", misalign_o, mis);
      check("hold_err", err_o, exp_err);
    end
    hold_i = 1'b0;
    mem_op_i = OP_NONE;
    @(negedge clk_i);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
  initial begin
    logic [3:0] op;
    logic [31:0] addr;
    rst_i = 1'b1; mem_op_i = OP_LW; ram_addr_i = 32'h10; ram_w_request_i = 1'b0;
    ram_data_i = '0; hold_i = 1'b0; sram_ready_i = 1'b0; sram_rdata_i = '0;
    rd_lat = 0; wr_lat = 0; ph = 0; wstable = 1'b1;
    for (int i = 0; i < 64; i++) begin
      sram[i] = $urandom;
      ref_mem[i] = sram[i];
    end
    repeat (3) @(negedge clk_i);
    #1;
    check("rst_stall", stall_o, 0);
    check("rst_ce", sram_ce_o, 0);
    check("rst_we", sram_we_o, 0);
    check("rst_rdata", rdata_o, 0);
    check("rst_mis", misalign_o, 0);
    check("rst_err", err_o, 0);
    check("rst_addr", sram_addr_o, 0);
    check("rst_wdata", sram_wdata_o, 0);
    rst_i = 1'b0; mem_op_i = OP_NONE;
    @(negedge clk_i);
    sram[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;
    access(OP_LW, 32'h10, 0, 0, 0, 0);
    check("lw_rdata", rdata_o, 32'hDEADBEEF);
    sram[4] = 32'h11223344; ref_mem[4] = 32'h11223344;
    access(OP_SB, 32'h11, 32'hAB, 0, 0, 0);
    check("sb_word", sram[4], 32'h1122AB44);
    access(OP_SW, 32'h20, 32'hCAFEF00D, 0, 3, 0);
    check("sw_word", sram[8], 32'hCAFEF00D);
    access(OP_LW, 32'h12, 0, 0, 0, 0);
    access(OP_LW, 32'h14, 0, 255, 0, 0);
    access(OP_LH, 32'h16, 0, TO, 0, 0);
    access(OP_SH, 32'h1A, 32'h5555, 2, TO + 1, 2);
    access(OP_LBU, 32'h03, 0, 1, 0, 3);
    access(OP_LB, 32'h41, 0, 0, 0, 0);
    mem_op_i = OP_LW; ram_addr_i = 32'h40; ram_w_request_i = 1'b0; rd_lat = 255;
    @(negedge clk_i);
    #1;
    check("rst_mid_ce_pre", sram_ce_o, 1);
    rst_i = 1'b1;
    @(negedge clk_i);
    #1;
    check("rst_mid_ce", sram_ce_o, 0);
    check("rst_mid_stall", stall_o, 0);
    rst_i = 1'b0; mem_op_i = OP_NONE;
    @(negedge clk_i);
    #1;
    check("rst_mid_idle", stall_o, 0);
    check("rst_mid_err", err_o, 0);
    @(negedge clk_i);
    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom_range(1, 8));
      addr = $urandom & 32'h0003_00FF;
      access(op, addr, $urandom, pick_lat(), pick_lat(), $urandom_range(0, 3) == 0 ? 2 : 0);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk_i);
        #1;
        check("idle_stall", stall_o, 0);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
